// File: rtl/secret_core_if.sv
// rtl/secret_core_if.sv - accumulator bus between a lane controller and secret_core
interface secret_core_if #(
  parameter int ACC_W = 32
);
  logic [ACC_W-1:0] accum_in;
  logic [ACC_W-1:0] accum_out;
  logic             accum_bypass;
  logic [ACC_W-1:0] accum_bypass_out;

  modport master (
    output accum_in,
    output accum_bypass,
    input  accum_out,
    input  accum_bypass_out
  );

  modport slave (
    input  accum_in,
    input  accum_bypass,
    output accum_out,
    output accum_bypass_out
  );
endinterface

// File: rtl/secret_core.sv
// rtl/secret_core.sv - free-running accumulator with hidden addend, bypass mux and wide pass-throughs
module secret_core #(
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] SECRET_VALUE = ACC_W'(7)
) (
  input  logic              clk,
  input  logic              rst_n,
  secret_core_if.slave      acc,
  input  logic              s1_in,
  output logic              s1_out,
  input  logic [1:0]        s2_in,
  output logic [1:0]        s2_out,
  input  logic [7:0]        s8_in,
  output logic [7:0]        s8_out,
  input  logic [32:0]       s33_in,
  output logic [32:0]       s33_out,
  input  logic [63:0]       s64_in,
  output logic [63:0]       s64_out,
  input  logic [64:0]       s65_in,
  output logic [64:0]       s65_out,
  input  logic [128:0]      s129_in,
  output logic [128:0]      s129_out,
  input  logic [3:0][31:0]  s4x32_in,
  output logic [3:0][31:0]  s4x32_out
);

  logic [ACC_W-1:0] acc_q;

  // Accumulates every cycle; the carry out of the top bit is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_q + acc.accum_in + SECRET_VALUE;
    end
  end

  assign acc.accum_out        = acc_q;
  assign acc.accum_bypass_out = acc.accum_bypass ? acc.accum_in : acc_q;

  assign s1_out    = s1_in;
  assign s2_out    = s2_in;
  assign s8_out    = s8_in;
  assign s33_out   = s33_in;
  assign s64_out   = s64_in;
  assign s65_out   = s65_in;
  assign s129_out  = s129_in;
  assign s4x32_out = s4x32_in;

endmodule

// File: tb/tb_secret_core.sv
// tb/tb_secret_core.sv - directed scoreboard bench for secret_core
module tb_secret_core;
  logic clk;
  logic rst_n;
  logic              s1_in,   s1_out;
  logic [1:0]        s2_in,   s2_out;
  logic [7:0]        s8_in,   s8_out;
  logic [32:0]       s33_in,  s33_out;
  logic [63:0]       s64_in,  s64_out;
  logic [64:0]       s65_in,  s65_out;
  logic [128:0]      s129_in, s129_out;
  logic [3:0][31:0]  s4x32_in, s4x32_out;

  secret_core_if #(.ACC_W(32)) acc_bus ();

  secret_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc       (acc_bus),
    .s1_in     (s1_in),
    .s1_out    (s1_out),
    .s2_in     (s2_in),
    .s2_out    (s2_out),
    .s8_in     (s8_in),
    .s8_out    (s8_out),
    .s33_in    (s33_in),
    .s33_out   (s33_out),
    .s64_in    (s64_in),
    .s64_out   (s64_out),
    .s65_in    (s65_in),
    .s65_out   (s65_out),
    .s129_in   (s129_in),
    .s129_out  (s129_out),
    .s4x32_in  (s4x32_in),
    .s4x32_out (s4x32_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model;
  logic [31:0] exp_q[$];
  logic [511:0] pat;
  logic [511:0] stim;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check the bypass mux combinationally, then the accumulator after the edge.
  task automatic cycle(input string tag, input logic rst, input logic [31:0] din, input logic byp,
                       input logic chk_byp);
    logic [31:0] got;
    rst_n = rst;
    acc_bus.accum_in = din;
    acc_bus.accum_bypass = byp;
    #1;
    if (chk_byp) check({tag, "_bypass"}, 256'(acc_bus.accum_bypass_out), 256'(byp ? din : model));
    model = rst ? (model + din + 32'd7) : 32'd0;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      got = exp_q.pop_front();
      check({tag, "_accum"}, 256'(acc_bus.accum_out), 256'(got));
    end
  endtask

  task automatic drive_pt(input logic [511:0] v);
    stim      = v;
    s1_in     = v[0];
    s2_in     = v[1:0];
    s8_in     = v[7:0];
    s33_in    = v[32:0];
    s64_in    = v[63:0];
    s65_in    = v[64:0];
    s129_in   = v[128:0];
    s4x32_in  = v[127:0];
  endtask

  task automatic check_pt(input string tag);
    check({tag, "_s1"},   256'(s1_out),   256'(stim[0]));
    check({tag, "_s2"},   256'(s2_out),   256'(stim[1:0]));
    check({tag, "_s8"},   256'(s8_out),   256'(stim[7:0]));
    check({tag, "_s33"},  256'(s33_out),  256'(stim[32:0]));
    check({tag, "_s64"},  256'(s64_out),  256'(stim[63:0]));
    check({tag, "_s65"},  256'(s65_out),  256'(stim[64:0]));
    check({tag, "_s129"}, 256'(s129_out), 256'(stim[128:0]));
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_s4x32_%0d", tag, k), 256'(s4x32_out[k]), 256'(stim[k*32 +: 32]));
  endtask

  initial begin
    model = 32'd0;
    pat = {8{64'h5aef0c8dd70a4497}};
    drive_pt(pat);
    @(negedge clk);

    // reset; accumulator is unknown before the first edge so only the bypass leg is checked
    cycle("reset", 1'b0, 32'h55, 1'b1, 1'b1);
    check_pt("pt_reset");

    cycle("idle1", 1'b1, 32'd0, 1'b0, 1'b1);
    cycle("idle2", 1'b1, 32'd0, 1'b0, 1'b1);
    cycle("idle3", 1'b1, 32'd0, 1'b0, 1'b1);
    check("idle_value", 256'(acc_bus.accum_out), 256'(32'd21));

    cycle("rst_b", 1'b0, 32'd0, 1'b0, 1'b1);
    cycle("hold1", 1'b1, 32'd100, 1'b0, 1'b1);
    cycle("hold2", 1'b1, 32'd100, 1'b0, 1'b1);
    cycle("hold3", 1'b1, 32'd100, 1'b0, 1'b1);
    check("hold_value", 256'(acc_bus.accum_out), 256'(32'd321));

    cycle("rst_c", 1'b0, 32'd0, 1'b0, 1'b1);
    cycle("ramp0", 1'b1, 32'd0, 1'b0, 1'b1);
    cycle("ramp5", 1'b1, 32'd5, 1'b0, 1'b1);
    cycle("ramp10", 1'b1, 32'd10, 1'b0, 1'b1);
    check("ramp_value", 256'(acc_bus.accum_out), 256'(32'd36));

    cycle("rst_d", 1'b0, 32'd0, 1'b0, 1'b1);
    cycle("wrap_pre", 1'b1, 32'hFFFF_FFF5, 1'b0, 1'b1);
    check("wrap_top", 256'(acc_bus.accum_out), 256'(32'hFFFF_FFFC));
    cycle("wrap", 1'b1, 32'd0, 1'b0, 1'b1);
    check("wrap_value", 256'(acc_bus.accum_out), 256'(32'h0000_0003));

    cycle("byp_on", 1'b1, 32'h1234, 1'b1, 1'b1);
    cycle("byp_off", 1'b1, 32'd0, 1'b0, 1'b1);

    // bypass stays live during reset
    cycle("byp_rst", 1'b0, 32'hABCD, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [511:0] r;
      for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
      drive_pt(r);
      #1;
      check_pt($sformatf("pt_rand%0d", i));
      cycle($sformatf("rand%0d", i), 1'b1, $urandom_range(0, 1000), 1'($urandom_range(0, 1)), 1'b1);
      check_pt($sformatf("pt_rand%0d_post", i));
    end

    drive_pt(pat);
    cycle("rst_e", 1'b0, 32'd0, 1'b0, 1'b1);
    cycle("to500", 1'b1, 32'd493, 1'b0, 1'b1);
    check("at500", 256'(acc_bus.accum_out), 256'(32'd500));
    cycle("mid_rst", 1'b0, 32'd5, 1'b0, 1'b1);
    check_pt("pt_mid_rst");
    check("mid_rst_zero", 256'(acc_bus.accum_out), 256'(32'd0));
    cycle("resume", 1'b1, 32'd5, 1'b0, 1'b1);
    check("resume_value", 256'(acc_bus.accum_out), 256'(32'd12));
    check_pt("pt_final");

    checks++;
    assert (exp_q.size() == 0)
    else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
